// File: rtl/minterm_pkg.sv
// Shared types and legal-range constants for the runtime-loadable minterm evaluator.
package minterm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    localparam int N_IN_MIN = 2;
    localparam int N_IN_MAX = 8;

endpackage

// File: rtl/minterm_sweep_ctrl.sv
// Sweep engine: walks every table index once and counts the true minterms.
module minterm_sweep_ctrl
    import minterm_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sweep_start,
    input  logic            tbl_bit,
    output logic [N_IN-1:0] tbl_idx,
    output logic            idle,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic [N_IN:0]   sweep_ones
);

    sweep_state_t    state;
    logic [N_IN-1:0] cnt;
    logic [N_IN:0]   acc;
    logic [N_IN:0]   acc_next;

    assign acc_next = acc + {{N_IN{1'b0}}, tbl_bit};
    assign tbl_idx  = cnt;
    assign idle     = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            acc        <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
            sweep_ones <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sweep_done <= 1'b0;
                    if (sweep_start) begin
                        state      <= ST_SWEEP;
                        cnt        <= '0;
                        acc        <= '0;
                        sweep_busy <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    // Stop on the all-ones index; the counter wraps to 0 on this step.
                    if (cnt == '1) begin
                        state      <= ST_DONE;
                        sweep_busy <= 1'b0;
                        sweep_done <= 1'b1;
                        sweep_ones <= acc_next;
                    end
                end
                ST_DONE: begin
                    sweep_done <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    sweep_busy <= 1'b0;
                    sweep_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/minterm_lut_eval.sv
// N_IN-input boolean function held as a loadable truth table, with a 1-cycle
// evaluation path and an on-chip sweep that counts the true minterms.
module minterm_lut_eval
    import minterm_pkg::*;
#(
    parameter int                   N_IN       = 4,
    parameter logic [(1<<N_IN)-1:0] DEFAULT_TT = 16'h5555
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    input  logic [(1<<N_IN)-1:0] cfg_data,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    output logic                 out_valid,
    output logic                 out_func,
    input  logic                 sweep_start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [N_IN:0]        sweep_ones
);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_n_in_range
        $error("minterm_lut_eval: N_IN out of range");
    end

    logic [(1<<N_IN)-1:0] tbl;
    logic [N_IN-1:0]      sweep_idx;
    logic                 sweep_idle;
    logic                 vld_p1;
    logic                 func_p1;

    assign cfg_ready = sweep_idle;
    assign out_valid = vld_p1;
    assign out_func  = func_p1;

    // Table load and evaluation share an edge, so a same-edge lookup sees the old table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl     <= DEFAULT_TT;
            vld_p1  <= 1'b0;
            func_p1 <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                tbl <= cfg_data;
            end
            vld_p1 <= in_valid;
            if (in_valid) begin
                func_p1 <= tbl[in_vec];
            end
        end
    end

    minterm_sweep_ctrl #(
        .N_IN (N_IN)
    ) u_sweep_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .sweep_start (sweep_start),
        .tbl_bit     (tbl[sweep_idx]),
        .tbl_idx     (sweep_idx),
        .idle        (sweep_idle),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_ones  (sweep_ones)
    );

endmodule

// File: tb/tb_minterm_lut_eval.sv
// Directed bench for minterm_lut_eval: table-driven evaluation vectors plus sweep sequences.
module tb_minterm_lut_eval;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic [15:0] cfg_data;
    logic        cfg_ready;
    logic        in_valid;
    logic [3:0]  in_vec;
    logic        out_valid;
    logic        out_func;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;
    logic [4:0]  sweep_ones;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cfg_v;
        logic [15:0] cfg_d;
        logic        in_v;
        logic [3:0]  vec;
        logic        exp_v;
        logic        exp_f;
    } vec_t;

    vec_t vt [11];

    always #5 clk = ~clk;

    minterm_lut_eval #(
        .N_IN       (4),
        .DEFAULT_TT (16'h5555)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_func    (out_func),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_ones  (sweep_ones)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_tbl(input logic [15:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        step;
        cfg_valid = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input logic do_load, input logic [15:0] load_d,
                             input int exp_ones, input logic [15:0] tbl_now);
        int         bc;
        logic       changed;
        logic       ready_seen;
        logic [4:0] prev;
        prev        = sweep_ones;
        sweep_start = 1'b1;
        cfg_valid   = do_load;
        cfg_data    = load_d;
        step;
        sweep_start = 1'b0;
        cfg_valid   = 1'b0;
        bc          = 0;
        changed     = 1'b0;
        ready_seen  = 1'b0;
        while (sweep_busy && bc < 40) begin
            bc++;
            if (sweep_ones != prev) changed = 1'b1;
            if (cfg_ready) ready_seen = 1'b1;
            // Mid-sweep restart and table load must both be ignored.
            if (bc == 3) begin
                sweep_start = 1'b1;
                cfg_valid   = 1'b1;
                cfg_data    = ~tbl_now;
            end else begin
                sweep_start = 1'b0;
                cfg_valid   = 1'b0;
            end
            step;
        end
        sweep_start = 1'b0;
        cfg_valid   = 1'b0;
        chk({tag, "_busy_cycles"}, bc, 16);
        chk({tag, "_done_pulse"}, int'(sweep_done), 1);
        chk({tag, "_ones"}, int'(sweep_ones), exp_ones);
        chk({tag, "_ones_stable"}, int'(changed), 0);
        chk({tag, "_ready_low"}, int'(ready_seen), 0);
        step;
        chk({tag, "_done_clear"}, int'(sweep_done), 0);
        chk({tag, "_ready_back"}, int'(cfg_ready), 1);
        chk({tag, "_ones_hold"}, int'(sweep_ones), exp_ones);
        in_valid = 1'b1;
        in_vec   = 4'd0;
        step;
        in_valid = 1'b0;
        chk({tag, "_tbl_kept"}, int'(out_func), int'(tbl_now[0]));
    endtask

    initial begin
        int pulses;

        vt[0]  = '{1'b0, 16'h0000, 1'b1, 4'd0,  1'b1, 1'b1};
        vt[1]  = '{1'b0, 16'h0000, 1'b1, 4'd1,  1'b1, 1'b0};
        vt[2]  = '{1'b0, 16'h0000, 1'b1, 4'd4,  1'b1, 1'b1};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 4'd5,  1'b1, 1'b0};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 4'd15, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 16'h8000, 1'b1, 4'd15, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 16'h0000, 1'b1, 4'd15, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b1};
        vt[8]  = '{1'b0, 16'h0000, 1'b1, 4'd14, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 16'h5555, 1'b1, 4'd0,  1'b1, 1'b0};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 4'd0,  1'b1, 1'b1};

        rst_n       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_data    = 16'h0000;
        in_valid    = 1'b0;
        in_vec      = 4'd0;
        sweep_start = 1'b0;
        step;
        step;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_func", int'(out_func), 0);
        chk("rst_busy", int'(sweep_busy), 0);
        chk("rst_done", int'(sweep_done), 0);
        chk("rst_ones", int'(sweep_ones), 0);
        rst_n = 1'b1;
        step;
        chk("rst_cfg_ready", int'(cfg_ready), 1);

        for (int i = 0; i < 11; i++) begin
            cfg_valid = vt[i].cfg_v;
            cfg_data  = vt[i].cfg_d;
            in_valid  = vt[i].in_v;
            in_vec    = vt[i].vec;
            step;
            chk($sformatf("eval%0d_valid", i), int'(out_valid), int'(vt[i].exp_v));
            chk($sformatf("eval%0d_func", i), int'(out_func), int'(vt[i].exp_f));
        end
        cfg_valid = 1'b0;
        in_valid  = 1'b0;

        run_sweep("default", 1'b0, 16'h0000, 8, 16'h5555);
        load_tbl(16'hFFFF);
        run_sweep("all_ones", 1'b0, 16'h0000, 16, 16'hFFFF);
        load_tbl(16'h0000);
        run_sweep("all_zero", 1'b0, 16'h0000, 0, 16'h0000);
        run_sweep("load_start", 1'b1, 16'h0F0F, 8, 16'h0F0F);
        load_tbl(16'h0001);
        run_sweep("single", 1'b0, 16'h0000, 1, 16'h0001);

        // Reset in the middle of a sweep, with the eval path holding a 1.
        in_valid = 1'b1;
        in_vec   = 4'd0;
        step;
        chk("mid_pre_func", int'(out_func), 1);
        sweep_start = 1'b1;
        step;
        sweep_start = 1'b0;
        for (int i = 0; i < 6; i++) step;
        chk("mid_busy_before", int'(sweep_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_func", int'(out_func), 0);
        chk("mid_rst_busy", int'(sweep_busy), 0);
        chk("mid_rst_done", int'(sweep_done), 0);
        chk("mid_rst_ones", int'(sweep_ones), 0);
        in_valid = 1'b0;
        step;
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (sweep_done) pulses++;
        end
        chk("mid_no_done", pulses, 0);
        run_sweep("post_reset", 1'b0, 16'h0000, 8, 16'h5555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
